mem_debug_ctrl: RTL

MEM_DEBUG_CTRL -- requirements
Module: mem_debug_ctrl

---
 rtl/mem_debug_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mem_debug_ctrl.sv
// ============================================================================
// Module   : mem_debug_ctrl (with package mem_cfg_pkg)
// Purpose  : Push-button memory inspector and debug writer. Four debounced
//            buttons step/home a current address and queue byte/word pattern
//            writes. A programmer byte-write port has zero-latency priority
//            access to the memory and holds off debug writes for a while
//            after its last write.
// Ports    : clk_i, rst_i          - clock, synchronous active-high reset
//            btn_i[3:0]            - raw buttons {word, byte, home, step}
//            prog_we_i/addr_i/data_i - programmer byte-write port
//            mem_addr_o/data_o/we_o/width_o - memory request
//            mem_dout_i            - memory read data
//            disp_addr_o/data_o    - inspection display
//            prog_busy_o           - programmer activity / holdoff
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_cfg_pkg;
  typedef enum logic {MEM_BYTE = 1'b0, MEM_WORD = 1'b1} mem_width_t;
endpackage

module mem_debug_ctrl
  import mem_cfg_pkg::*;
#(
  parameter int              ADDR_W          = 10,
  parameter int              DATA_W          = 32,
  parameter int              DEBOUNCE_CYCLES = 100000,
  parameter int              REPEAT_CYCLES   = 25000000,
  parameter int              STEP            = 1,
  parameter int              HOLDOFF_CYCLES  = 16,
  parameter logic [7:0]      PATTERN_B       = 8'hA7,
  parameter logic [DATA_W-1:0] PATTERN_W     = DATA_W'(32'h0DEFACED)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [3:0]        btn_i,
  input  logic              prog_we_i,
  input  logic [ADDR_W-1:0] prog_addr_i,
  input  logic [7:0]        prog_data_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_we_o,
  output mem_width_t        mem_width_o,
  input  logic [DATA_W-1:0] mem_dout_i,
  output logic [ADDR_W-1:0] disp_addr_o,
  output logic [DATA_W-1:0] disp_data_o,
  output logic              prog_busy_o
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam int HO_W  = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);
  localparam logic [HO_W-1:0]   HOLD_LOAD = HO_W'(HOLDOFF_CYCLES);
  localparam logic [ADDR_W-1:0] STEP_INC  = ADDR_W'(STEP);

  typedef enum logic [1:0] {IDLE = 2'd0, PROG = 2'd1, DBG_WR = 2'd2} state_t;

  state_t            state, next_state;
  logic [3:0]        level;       // accepted (debounced) button levels
  logic [3:0]        level_q;     // accepted levels one cycle ago
  logic [3:0]        press;
  logic [REP_W-1:0]  rep_cnt;
  logic [HO_W-1:0]   hold_cnt;
  logic [ADDR_W-1:0] cur_addr;
  logic              pend_valid;
  mem_width_t        pend_width;
  logic              step_evt, do_step, do_home, do_byte, do_word, consume;

  // btn_i is sampled directly; the debounce window absorbs bounce and the
  // buttons are assumed to be synchronised to clk_i upstream.
  for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
    logic            lvl;
    logic [DB_W-1:0] cnt;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        lvl <= 1'b0;
        cnt <= '0;
      end else if (btn_i[gi] != lvl) begin
        if (cnt == DB_LAST) begin
          lvl <= btn_i[gi];
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
    assign level[gi] = lvl;
  end

  assign press = level & ~level_q;

  // rep_cnt is 0 in the press cycle and wraps every REPEAT_CYCLES while the
  // step level is held, so a wrap back to 0 marks each auto-repeat.
  assign step_evt = press[0] | (level[0] & level_q[0] & (rep_cnt == '0));

  // Lowest-index event wins; the rest are dropped.
  assign do_step = step_evt;
  assign do_home = press[1] & ~step_evt;
  assign do_byte = press[2] & ~step_evt & ~press[1];
  assign do_word = press[3] & ~step_evt & ~press[1] & ~press[2];
  assign consume = (state == DBG_WR) & ~prog_we_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q    <= '0;
      rep_cnt    <= '0;
      hold_cnt   <= '0;
      cur_addr   <= '0;
      pend_valid <= 1'b0;
      pend_width <= MEM_BYTE;
    end else begin
      level_q <= level;
      if (!level[0] || rep_cnt == REP_LAST) rep_cnt <= '0;
      else                                 rep_cnt <= rep_cnt + 1'b1;
      if (do_step)      cur_addr <= cur_addr + STEP_INC;
      else if (do_home) cur_addr <= '0;
      if (prog_we_i)            hold_cnt <= HOLD_LOAD;
      else if (hold_cnt != '0)  hold_cnt <= hold_cnt - 1'b1;
      // A newly queued write takes precedence over consuming the old one.
      if (do_byte) begin
        pend_valid <= 1'b1;
        pend_width <= MEM_BYTE;
      end else if (do_word) begin
        pend_valid <= 1'b1;
        pend_width <= MEM_WORD;
      end else if (consume) begin
        pend_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    next_state  = state;
    mem_addr_o  = cur_addr;
    mem_data_o  = '0;
    mem_width_o = MEM_BYTE;
    mem_we_o    = 1'b0;
    case (state)
      IDLE: begin
        if (prog_we_i)       next_state = PROG;
        else if (pend_valid) next_state = DBG_WR;
      end
      // Leaving on hold_cnt==1 makes the counter hit 0 on the same edge,
      // giving exactly HOLDOFF_CYCLES busy cycles after the last write.
      PROG: begin
        if (!prog_we_i && hold_cnt <= HO_W'(1)) next_state = IDLE;
      end
      DBG_WR:  next_state = prog_we_i ? PROG : IDLE;
      default: next_state = IDLE;
    endcase
    // The programmer path is purely combinational so it also works in reset.
    if (prog_we_i) begin
      mem_addr_o  = prog_addr_i;
      mem_data_o  = DATA_W'(prog_data_i);
      mem_width_o = MEM_BYTE;
      mem_we_o    = 1'b1;
    end else if (state == DBG_WR) begin
      mem_we_o    = 1'b1;
      mem_width_o = pend_width;
      mem_data_o  = (pend_width == MEM_WORD) ? PATTERN_W : DATA_W'(PATTERN_B);
    end
  end

  assign prog_busy_o = prog_we_i | (state == PROG);
  assign disp_addr_o = cur_addr;
  assign disp_data_o = prog_busy_o ? '0 : mem_dout_i;

endmodule

`default_nettype wire
